ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter LAYER, default 1: layer tag, no functional effect.
REQ-002 SHALL have parameter ID, default 1: instance tag, no functional effect.
REQ-003 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-004 SHALL have parameter SIZE, default 512: RAM depth in entries; AW = $clog2(SIZE).
REQ-005 SHALL have a single clock and an asynchronous, active-low reset, as these ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have these remaining ports:
- start  in  1  one-cycle pulse that requests a burst.
- base_addr  in  AW  first RAM address, sampled with start.
- len  in  AW+1  beats to read, 0..SIZE, sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- raddr  out  AW  RAM read address, wired to the RAM read port.
- read_data  in  WIDTH  RAM read data, valid one cycle after raddr is presented.
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  marks the final beat of the burst.

Function
REQ-007 SHALL accept start only when busy=0; a start pulse while busy=1 (including the done cycle) SHALL be ignored.
REQ-008 SHALL implement FSM IDLE -> RUN (start accepted, len>0) -> DRAIN (all reads issued) -> IDLE (last beat accepted). IDLE -> IDLE when len=0.
REQ-009 SHALL assert busy from the cycle after start is accepted through the done cycle inclusive.
REQ-010 SHALL issue reads at base_addr, base_addr+1, ... modulo SIZE; the address SHALL wrap from SIZE-1 to 0.
REQ-011 SHALL present the first raddr in cycle 1 and capture read_data in cycle 2; with m_ready=1, m_valid SHALL first rise in cycle 3 (start = cycle 0).
REQ-012 SHALL buffer returned words in an internal FIFO of depth 4.
REQ-013 SHALL issue a read only when FIFO occupancy plus in-flight reads is less than 4, so no returned word is ever dropped.
REQ-014 SHALL sustain one beat per cycle while m_ready stays high.
REQ-015 SHALL transfer a beat when m_valid & m_ready; m_data, m_last and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 SHALL deliver exactly len beats in address order and assert m_last on beat len only.
REQ-017 SHALL pulse done in the cycle after the m_last handshake; for len=0 it SHALL instead pulse done in cycle 1 with no beats and no reads.
REQ-018 SHALL not assert m_valid when busy=0.
REQ-019 SHALL handle len=SIZE as a full-RAM read ending at address base_addr-1 (mod SIZE).
REQ-020 SHALL hold raddr at its last value when no read is issued; the RAM read has no enable, so extra reads are harmless but their data SHALL be discarded.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-burst, immediately set the FSM to IDLE and clear busy, done, m_valid and m_last to 0.
REQ-022 SHALL, on that reset, set raddr to 0, empty the FIFO and clear the in-flight count.
REQ-023 SHALL discard RAM data returning after reset deassertion and drive no beats until a new start.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, RUN, DRAIN) and the FIFO depth constant (4) in the shared HLS package.
REQ-025 SHALL implement the FIFO as the sub-module stream_fifo (params WIDTH, DEPTH; push/pop/count/full/empty), on the same clk and rst_n.

Verification
REQ-026 SHALL cover start, base=10, len=4, m_ready=1, RAM[i]=i -> m_valid first in cycle 3; beats 10,11,12,13 on consecutive cycles; m_last on 13; done one cycle later.
REQ-027 SHALL cover base=510, len=4, SIZE=512 -> raddr sequence 510,511,0,1 and data in that order.
REQ-028 SHALL cover len=6 with m_ready toggling 1,0,0,1,... -> no lost or duplicated beat, data held stable while stalled, FIFO never overflows.
REQ-029 SHALL cover len=0 -> done pulse in cycle 1, m_valid never asserted; and start pulsed mid-burst -> ignored, beat count unchanged.
REQ-030 SHALL cover rst_n low after beat 2 of len=8 -> outputs 0 asynchronously; a new start (base=0, len=2) then delivers exactly RAM[0], RAM[1].
REQ-031 SHALL cover len=512, m_ready=1 -> 512 beats in 512 consecutive cycles, m_last only on the final beat.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM burst-to-stream reader: controller states and
// the return-buffer depth that bounds outstanding reads.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// Small synchronous FIFO with occupancy count; the head word is presented
// combinationally so it stays stable until popped.
module stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive (wrapping) RAM words through a synchronous read
// port and presents them as a valid/ready stream with a last-beat marker.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int LAYER = 1,
    parameter int ID    = 1,
    parameter int WIDTH = 16,
    parameter int SIZE  = 512,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);
    localparam int OW = FIFO_CW + 1;

    state_t               state;
    logic [AW:0]          issue_left;
    logic [AW:0]          beats_left;
    logic                 vld_p0;
    logic                 vld_p1;
    logic                 accept;
    logic                 can_issue;
    logic                 fire;
    logic [OW-1:0]        pending;
    logic [FIFO_CW-1:0]   fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_tag;

    // Tag parameters have no function; fold them into an ignored net.
    assign unused_tag = ^{32'(LAYER), 32'(ID), fifo_full};

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(SIZE - 1)) ? '0 : a + 1'b1;
    endfunction

    // Buffered words plus reads still in the RAM pipe must never exceed the FIFO.
    assign pending   = OW'(fifo_count) + OW'(vld_p0) + OW'(vld_p1);
    assign accept    = start && !busy;
    assign can_issue = (state == RUN) && (issue_left != '0) && (pending < OW'(FIFO_DEPTH));
    assign m_valid   = (state != IDLE) && !fifo_empty;
    assign m_last    = m_valid && (beats_left == (AW+1)'(1));
    assign fire      = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            raddr      <= '0;
            issue_left <= '0;
            beats_left <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            // p0: address presented this cycle; p1: its data is on read_data
            vld_p1 <= vld_p0;
            vld_p0 <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= RUN;
                            raddr      <= base_addr;
                            vld_p0     <= 1'b1;
                            issue_left <= len - 1'b1;
                            beats_left <= len;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        raddr      <= next_addr(raddr);
                        vld_p0     <= 1'b1;
                        issue_left <= issue_left - 1'b1;
                    end
                    if (issue_left == '0) state <= DRAIN;
                end
                default: ;
            endcase
            if (fire) begin
                beats_left <= beats_left - 1'b1;
                if (m_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (read_data),
        .pop       (fire),
        .pop_data  (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
